// File: rtl/fir_iq_decim.sv
// Multi-channel FIR low-pass for the Costas I/Q arms: shared run-time loadable
// coefficients (shadow/active banks), optional decimation, round-half-up and saturation.
module fir_iq_decim #(
  parameter int NCH   = 2,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int NTAPS = 43,
  parameter int DECIM = 1,
  parameter int SHIFT = 8,
  parameter int OW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NCH*DW-1:0]        in_data,
  input  logic                     coef_wr,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [CW-1:0]            coef_data,
  input  logic                     coef_commit,
  output logic                     out_valid,
  output logic [NCH*OW-1:0]        out_data,
  output logic [NCH-1:0]           out_sat
);
  localparam int AAW      = $clog2(NTAPS);
  localparam int PW       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PRW      = DW + CW;
  localparam int AW       = DW + CW + $clog2(NTAPS);
  localparam int AW1      = AW + 1;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [OW-1:0]        OMAX_O = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]        OMIN_O = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [AW:0]   OMAX   = {{(AW1-OW){1'b0}}, OMAX_O};
  localparam logic signed [AW:0]   OMIN   = {{(AW1-OW){1'b1}}, OMIN_O};

  logic signed [DW-1:0]  r_delay      [NCH][NTAPS-1];
  logic signed [CW-1:0]  r_coef_sh    [NTAPS];
  logic signed [CW-1:0]  r_coef_act   [NTAPS];
  logic signed [CW-1:0]  w_coef_sh_nxt[NTAPS];
  logic [PW-1:0]         r_phase;
  logic signed [DW-1:0]  w_tap        [NCH][NTAPS];
  logic signed [PRW-1:0] r_prod_p1    [NCH][NTAPS];
  logic                  r_vld_p1;
  logic signed [AW-1:0]  w_sum        [NCH];
  logic signed [AW-1:0]  r_acc_p2     [NCH];
  logic                  r_vld_p2;

  // Round half toward +inf, evaluated one bit wider than the accumulator.
  function automatic logic signed [AW:0] f_round(input logic signed [AW-1:0] acc);
    logic signed [AW:0] ext;
    logic signed [AW:0] rnd;
    ext = AW1'(acc);
    rnd = '0;
    if (SHIFT > 0) rnd[SHIFT_M1] = 1'b1;
    return (ext + rnd) >>> SHIFT;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OW:0] f_sat(input logic signed [AW:0] r);
    if (r > OMAX) return {1'b1, OMAX_O};
    if (r < OMIN) return {1'b1, OMIN_O};
    return {1'b0, r[OW-1:0]};
  endfunction

  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      w_coef_sh_nxt[k] = r_coef_sh[k];
      if (coef_wr && (coef_addr == AAW'(k))) w_coef_sh_nxt[k] = coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_coef_sh[k]  <= '0;
        r_coef_act[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) r_coef_sh[k] <= w_coef_sh_nxt[k];
      if (coef_commit)
        for (int k = 0; k < NTAPS; k++) r_coef_act[k] <= w_coef_sh_nxt[k];
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_tap[c][0] = in_data[c*DW +: DW];
      for (int k = 1; k < NTAPS; k++) w_tap[c][k] = r_delay[c][k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS-1; k++) r_delay[c][k] <= '0;
    end else if (in_valid) begin
      r_phase <= (r_phase == PW'(DECIM-1)) ? '0 : r_phase + 1'b1;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS-1; k++) r_delay[c][k] <= w_tap[c][k];
    end
  end

  // S1: products against the active bank as it stands in the acceptance cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++) r_prod_p1[c][k] <= '0;
    end else begin
      r_vld_p1 <= in_valid && (r_phase == '0);
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++)
          r_prod_p1[c][k] <= PRW'(w_tap[c][k]) * PRW'(r_coef_act[k]);
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_sum[c] = '0;
      for (int k = 0; k < NTAPS; k++) w_sum[c] = w_sum[c] + AW'(r_prod_p1[c][k]);
    end
  end

  // S2: per-channel accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2 <= 1'b0;
      for (int c = 0; c < NCH; c++) r_acc_p2[c] <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      for (int c = 0; c < NCH; c++) r_acc_p2[c] <= w_sum[c];
    end
  end

  // S3: scale and clamp; results hold between output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      out_valid <= r_vld_p2;
      if (r_vld_p2)
        for (int c = 0; c < NCH; c++)
          {out_sat[c], out_data[c*OW +: OW]} <= f_sat(f_round(r_acc_p2[c]));
    end
  end

endmodule
